// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO pair.
// Define MIPS_MULDIV_FASTMUL_EN for a single-cycle combinational multiply.
module mips_muldiv #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        div0;

    logic        sgn_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [33:0] div_diff;
    logic [63:0] step_acc;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        sgn_op = (op_code == 3'd0) || (op_code == 3'd2);
        a_neg  = sgn_op && op_a[31];
        b_neg  = sgn_op && op_b[31];
        abs_a  = a_neg ? -op_a : op_a;
        abs_b  = b_neg ? -op_b : op_b;
    end

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
        div_diff = {1'b0, acc[63:31]} - {2'b00, mag_b};
        if (is_div) begin
            if (!div_diff[33])
                step_acc = {div_diff[31:0], acc[30:0], 1'b1};
            else
                step_acc = {acc[62:0], 1'b0};
        end else begin
            step_acc = {mul_sum, acc[31:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quot_fix = div0 ? DIV0_LO : (neg_q ? -acc[31:0] : acc[31:0]);
        rem_fix  = neg_r ? -acc[63:32] : acc[63:32];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (op_valid && !abort) begin
                        unique case (op_code)
                            3'd4: hi <= op_a;
                            3'd5: lo <= op_a;
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                mag_a  <= abs_a;
                                mag_b  <= abs_b;
                                is_div <= op_code[1];
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                div0   <= op_code[1] && (op_b == 32'd0);
                                cnt    <= 5'd0;
                                busy   <= 1'b1;
`ifdef MIPS_MULDIV_FASTMUL_EN
                                if (op_code[1]) begin
                                    acc   <= {32'd0, abs_a};
                                    state <= RUN;
                                end else begin
                                    acc   <= {32'd0, abs_a} * {32'd0, abs_b};
                                    state <= FIX;
                                end
`else
                                acc   <= {32'd0, (op_code[1] ? abs_a : abs_b)};
                                state <= RUN;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= step_acc;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31)
                            state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!abort) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
